// File: rtl/mul_div_queue_ctrl.sv
// Issue-queue controller for the mul/div reservation chain: strobes, bubble collapse,
// oldest-ready issue select and divider occupancy tracking.
module mul_div_queue_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_disp_valid,
    output logic             o_disp_ready_c,
    input  logic [DEPTH-1:0] i_entry_valid,
    input  logic [DEPTH-1:0] i_entry_ready,
    input  logic [DEPTH-1:0] i_entry_is_div,
    input  logic [DEPTH-1:0] i_op1_cdb_match,
    input  logic [DEPTH-1:0] i_op2_cdb_match,
    input  logic             i_disp_op1_cdb_match,
    input  logic             i_disp_op2_cdb_match,
    output logic [DEPTH-1:0] o_we_c,
    output logic [DEPTH-1:0] o_updt_cmn_block_c,
    output logic [DEPTH-1:0] o_updt_op1_c,
    output logic [DEPTH-1:0] o_updt_op1_from_cdb_c,
    output logic [DEPTH-1:0] o_updt_op2_c,
    output logic [DEPTH-1:0] o_updt_op2_from_cdb_c,
    output logic [DEPTH-1:0] o_src_valid_c,
    output logic             o_issue_valid_c,
    output logic [2:0]       o_issue_idx_c,
    input  logic             i_issue_ack,
    output logic             o_div_busy,
    output logic [3:0]       o_occupancy
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned OCC_W = 4;
    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    logic [CNT_W-1:0] r_div_cnt;
    logic             r_div_busy;
    logic [OCC_W-1:0] r_occupancy;

    logic             w_block;
    logic [DEPTH-1:0] w_cand;
    logic [DEPTH-1:0] w_sel_oh;
    logic [DEPTH-1:0] w_taken_oh;
    logic [IDX_W-1:0] w_issue_idx;
    logic             w_issue_valid;
    logic             w_sel_is_div;
    logic             w_iss;
    logic [DEPTH-1:0] w_hole;
    logic [DEPTH-1:0] w_shift;
    logic             w_disp_ready;
    logic             w_accept;
    logic [DEPTH-1:0] w_up_valid;
    logic [DEPTH-1:0] w_up_op1;
    logic [DEPTH-1:0] w_up_op2;
    logic [DEPTH-1:0] w_gate;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Reset and flush cycles suppress issue, accept and all entry strobes
    assign w_block = i_rst | i_flush;
    assign w_gate  = {DEPTH{~w_block}};

    // Ready entries, with divs held back while the divider is occupied
    assign w_cand = i_entry_valid & i_entry_ready
                  & ~(i_entry_is_div & {DEPTH{r_div_busy}}) & w_gate;

    // Lowest-index (oldest) candidate wins
    always_comb begin
        w_issue_idx  = '0;
        w_sel_oh     = '0;
        w_sel_is_div = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_issue_idx  = IDX_W'(i);
                w_sel_oh     = '0;
                w_sel_oh[i]  = 1'b1;
                w_sel_is_div = i_entry_is_div[i];
            end
        end
    end

    assign w_issue_valid = |w_cand;
    assign w_iss         = w_issue_valid & i_issue_ack;
    assign w_taken_oh    = w_sel_oh & {DEPTH{w_iss}};

    // Hole below entry i: issued at or below i, or an empty slot below i
    always_comb begin
        logic v_gap;
        logic v_seen;
        v_gap  = 1'b0;
        v_seen = 1'b0;
        w_hole = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v_seen    = v_seen | w_taken_oh[i];
            w_hole[i] = v_gap | v_seen;
            v_gap     = v_gap | ~i_entry_valid[i];
        end
    end

    assign w_shift      = w_hole | ~i_entry_valid;
    assign w_disp_ready = ~w_block & w_shift[DEPTH-1];
    assign w_accept     = i_disp_valid & w_disp_ready;

    // Upper-neighbour source per entry; the tail's neighbour is the dispatch bus
    assign w_up_valid = {w_accept, i_entry_valid[DEPTH-1:1] & ~w_taken_oh[DEPTH-1:1]};
    assign w_up_op1   = {i_disp_op1_cdb_match, i_op1_cdb_match[DEPTH-1:1]};
    assign w_up_op2   = {i_disp_op2_cdb_match, i_op2_cdb_match[DEPTH-1:1]};

    // Per-entry strobes: full reload on shift, otherwise CDB capture only
    assign o_we_c                = w_gate & (w_shift | i_op1_cdb_match | i_op2_cdb_match);
    assign o_updt_cmn_block_c    = w_gate & w_shift;
    assign o_updt_op1_c          = w_gate & (w_shift | i_op1_cdb_match);
    assign o_updt_op2_c          = w_gate & (w_shift | i_op2_cdb_match);
    assign o_updt_op1_from_cdb_c = w_gate & ((w_shift & w_up_op1) | (~w_shift & i_op1_cdb_match));
    assign o_updt_op2_from_cdb_c = w_gate & ((w_shift & w_up_op2) | (~w_shift & i_op2_cdb_match));
    assign o_src_valid_c         = w_up_valid;

    assign o_disp_ready_c  = w_disp_ready;
    assign o_issue_valid_c = w_issue_valid;
    assign o_issue_idx_c   = w_issue_idx;

    // Next occupancy, saturating within 0..DEPTH
    always_comb begin
        w_occ_nxt = r_occupancy;
        if (w_accept && !w_iss) begin
            if (r_occupancy < OCC_W'(DEPTH)) begin
                w_occ_nxt = r_occupancy + OCC_W'(1);
            end
        end else if (!w_accept && w_iss) begin
            if (r_occupancy != '0) begin
                w_occ_nxt = r_occupancy - OCC_W'(1);
            end
        end
    end

    // Next divider countdown; a div issue reloads it
    always_comb begin
        w_cnt_nxt = r_div_cnt;
        if (w_iss && w_sel_is_div) begin
            w_cnt_nxt = CNT_W'(DIV_CYCLES - 1);
        end else if (r_div_cnt != '0) begin
            w_cnt_nxt = r_div_cnt - CNT_W'(1);
        end
    end

    // Controller state registers
    always_ff @(posedge i_clk) begin
        if (w_block) begin
            r_occupancy <= '0;
            r_div_cnt   <= '0;
            r_div_busy  <= 1'b0;
        end else begin
            r_occupancy <= w_occ_nxt;
            r_div_cnt   <= w_cnt_nxt;
            r_div_busy  <= (w_cnt_nxt != '0);
        end
    end

    assign o_div_busy  = r_div_busy;
    assign o_occupancy = r_occupancy;

endmodule

// File: tb/tb_mul_div_queue_ctrl.sv
// Directed bench for mul_div_queue_ctrl (DEPTH=4, DIV_CYCLES=16).
module tb_mul_div_queue_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, disp_valid, disp_ready;
    logic [3:0] entry_valid, entry_ready, entry_is_div, op1_m, op2_m;
    logic       disp_op1_m, disp_op2_m;
    logic [3:0] we, cmn, u1, u1c, u2, u2c, srcv;
    logic       issue_valid, issue_ack, div_busy;
    logic [2:0] issue_idx;
    logic [3:0] occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_div_queue_ctrl #(.DEPTH(4), .DIV_CYCLES(16)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_flush               (flush),
        .i_disp_valid          (disp_valid),
        .o_disp_ready_c        (disp_ready),
        .i_entry_valid         (entry_valid),
        .i_entry_ready         (entry_ready),
        .i_entry_is_div        (entry_is_div),
        .i_op1_cdb_match       (op1_m),
        .i_op2_cdb_match       (op2_m),
        .i_disp_op1_cdb_match  (disp_op1_m),
        .i_disp_op2_cdb_match  (disp_op2_m),
        .o_we_c                (we),
        .o_updt_cmn_block_c    (cmn),
        .o_updt_op1_c          (u1),
        .o_updt_op1_from_cdb_c (u1c),
        .o_updt_op2_c          (u2),
        .o_updt_op2_from_cdb_c (u2c),
        .o_src_valid_c         (srcv),
        .o_issue_valid_c       (issue_valid),
        .o_issue_idx_c         (issue_idx),
        .i_issue_ack           (issue_ack),
        .o_div_busy            (div_busy),
        .o_occupancy           (occupancy)
    );

    typedef struct {
        logic       rst, flush, dv;
        logic [3:0] v, rdy, m1, m2;
        logic       d1, d2, ack;
        logic       e_dr, e_iv;
        logic [2:0] e_idx;
        logic [3:0] e_we, e_cmn, e_u1, e_u1c, e_u2, e_u2c, e_src;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ack = 1'b0;
        entry_valid = '0; entry_ready = '0; entry_is_div = '0;
        op1_m = '0; op2_m = '0; disp_op1_m = 1'b0; disp_op2_m = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        //         rst flush dv  v        rdy      m1       m2       d1 d2 ack  dr iv idx  we       cmn      u1       u1c      u2       u2c      src
        tbl[0]  = '{1, 0, 1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1, 1, 1,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111};
        tbl[1]  = '{0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0,  1, 0, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1000};
        tbl[2]  = '{0, 0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0,  1, 1, 0, 4'b1110, 4'b1110, 4'b1110, 4'b1000, 4'b1110, 4'b0000, 4'b1000};
        tbl[3]  = '{0, 0, 0, 4'b0111, 4'b0110, 4'b0001, 4'b0000, 0, 0, 1,  1, 1, 1, 4'b1111, 4'b1110, 4'b1111, 4'b0001, 4'b1110, 4'b0000, 4'b0010};
        tbl[4]  = '{0, 0, 1, 4'b0111, 4'b0010, 4'b0000, 4'b0100, 0, 0, 1,  1, 1, 1, 4'b1110, 4'b1110, 4'b1110, 4'b0000, 4'b1110, 4'b0010, 4'b1010};
        tbl[5]  = '{0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 0, 0, 0,  0, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0111};
        tbl[6]  = '{0, 0, 1, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0,  0, 1, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111};
        tbl[7]  = '{0, 0, 1, 4'b1111, 4'b1000, 4'b0000, 4'b0000, 1, 1, 1,  1, 1, 3, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1011};
        tbl[8]  = '{0, 0, 0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0,  1, 0, 0, 4'b1110, 4'b1110, 4'b1110, 4'b0000, 4'b1110, 4'b0000, 4'b0110};
        tbl[9]  = '{0, 1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111};
        tbl[10] = '{0, 0, 0, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 0, 0, 0,  1, 0, 0, 4'b1111, 4'b1100, 4'b1101, 4'b0001, 4'b1110, 4'b0010, 4'b0001};

        do_reset();
        chk("reset_occ", int'(occupancy), 0);
        chk("reset_busy", int'(div_busy), 0);

        // Combinational strobe vectors (no div ops, so divider stays idle)
        for (int k = 0; k < 11; k++) begin
            rst = tbl[k].rst; flush = tbl[k].flush; disp_valid = tbl[k].dv;
            entry_valid = tbl[k].v; entry_ready = tbl[k].rdy; entry_is_div = '0;
            op1_m = tbl[k].m1; op2_m = tbl[k].m2;
            disp_op1_m = tbl[k].d1; disp_op2_m = tbl[k].d2; issue_ack = tbl[k].ack;
            #1;
            chk($sformatf("v%0d_disp_ready", k), int'(disp_ready), int'(tbl[k].e_dr));
            chk($sformatf("v%0d_issue_valid", k), int'(issue_valid), int'(tbl[k].e_iv));
            if (tbl[k].e_iv) chk($sformatf("v%0d_issue_idx", k), int'(issue_idx), int'(tbl[k].e_idx));
            chk($sformatf("v%0d_we", k), int'(we), int'(tbl[k].e_we));
            chk($sformatf("v%0d_cmn", k), int'(cmn), int'(tbl[k].e_cmn));
            chk($sformatf("v%0d_op1", k), int'(u1), int'(tbl[k].e_u1));
            chk($sformatf("v%0d_op1_cdb", k), int'(u1c), int'(tbl[k].e_u1c));
            chk($sformatf("v%0d_op2", k), int'(u2), int'(tbl[k].e_u2));
            chk($sformatf("v%0d_op2_cdb", k), int'(u2c), int'(tbl[k].e_u2c));
            chk($sformatf("v%0d_src_valid", k), int'(srcv), int'(tbl[k].e_src));
            tick();
        end

        // Fill three entries from empty, no issue ack
        do_reset();
        for (int k = 0; k < 3; k++) begin
            entry_valid = 4'((1 << k) - 1); entry_ready = entry_valid;
            disp_valid = 1'b1;
            #1;
            chk($sformatf("fill%0d_disp_ready", k), int'(disp_ready), 1);
            tick();
            chk($sformatf("fill%0d_occ", k), int'(occupancy), k + 1);
        end
        entry_valid = 4'b0111; entry_ready = 4'b0111;
        #1;
        chk("fill_issue_idx", int'(issue_idx), 0);
        tick();
        chk("full_occ", int'(occupancy), 4);

        // Full queue blocks dispatch until an issue frees the tail
        entry_valid = 4'b1111; entry_ready = 4'b1111;
        #1;
        chk("full_disp_ready", int'(disp_ready), 0);
        tick();
        chk("full_hold_occ", int'(occupancy), 4);
        issue_ack = 1'b1;
        #1;
        chk("full_ack_disp_ready", int'(disp_ready), 1);
        tick();
        chk("accept_and_issue_occ", int'(occupancy), 4);
        disp_valid = 1'b0;
        tick();
        chk("issue_only_occ", int'(occupancy), 3);

        // Div issue, then div skipped while busy, mul still issues
        do_reset();
        entry_valid = 4'b0011; entry_ready = 4'b0011; entry_is_div = 4'b0001;
        issue_ack = 1'b1;
        #1;
        chk("div_issue_idx", int'(issue_idx), 0);
        tick();
        chk("div_busy_set", int'(div_busy), 1);
        chk("occ_floor", int'(occupancy), 0);
        issue_ack = 1'b0;
        #1;
        chk("div_skip_valid", int'(issue_valid), 1);
        chk("div_skip_idx", int'(issue_idx), 1);
        n = 1;
        while (div_busy && n < 40) begin
            tick();
            if (div_busy) n++;
        end
        chk("div_busy_cycles", n, 15);
        chk("div_unblocked_idx", int'(issue_idx), 0);

        // Flush with three valid entries and the divider busy
        do_reset();
        for (int k = 0; k < 3; k++) begin
            entry_valid = 4'((1 << k) - 1); entry_ready = '0;
            disp_valid = 1'b1;
            tick();
        end
        entry_valid = 4'b0111; entry_ready = 4'b0001; entry_is_div = 4'b0001;
        issue_ack = 1'b1;
        tick();
        chk("pre_flush_occ", int'(occupancy), 3);
        chk("pre_flush_busy", int'(div_busy), 1);
        flush = 1'b1; entry_ready = 4'b0111; entry_is_div = '0;
        #1;
        chk("flush_issue_valid", int'(issue_valid), 0);
        chk("flush_disp_ready", int'(disp_ready), 0);
        tick();
        flush = 1'b0; entry_valid = '0; entry_ready = '0; disp_valid = 1'b0;
        #1;
        chk("post_flush_occ", int'(occupancy), 0);
        chk("post_flush_busy", int'(div_busy), 0);
        chk("post_flush_issue_valid", int'(issue_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
